step_scheduler: RTL
===================

Name: step_scheduler

Overview:
- Sequencer for the systolic-line `step` datapath. It runs a full GF(M) Gaussian-elimination sweep over the L x K matrix held in step's data memory.
- For each phase it issues one functionA (pivot/op-generation) pass on the diagonal column block. It then issues functionB (op-application) passes on every column block to the right.
- It holds the step configuration stable while a pass runs, detects failures and timeouts, and grants host memory-port access only while the matrix is quiescent.

Parameters:
- N, 4, systolic line width (same as step)
- M, 3, field size (same as step)
- L, 8, matrix rows; constraint L <= K
- K, 16, matrix columns; K % N == 0
- GAP, 2, idle cycles inserted after each step_done before the next step_start (pipeline drain)
- FPR_OFFSET, 8, added to col_block*L to form first_pass_rows (default 2*N)
- TIMEOUT, 1024, max cycles in WAIT before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start a sweep; sampled only in IDLE, FINISH or FAIL
- busy  out  1  high in any state except IDLE, FINISH, FAIL
- done  out  1  one-cycle pulse on successful completion
- fail  out  1  sticky failure flag; cleared by go or rst
- timeout  out  1  sticky; set together with fail when the watchdog fires
- fail_phase  out  `CLOG2(L/N+2)  phase index at failure
- host_gnt  out  1  host may drive step rd_en/wr_en; equals !busy
- step_start  out  1  one-cycle start pulse to step
- step_functionA  out  1  pass type
- step_last_phase  out  1  current phase is the final phase
- step_col_block  out  `CLOG2(K/N+1)  column block of the current pass
- step_first_pass_rows  out  `CLOG2(L*K/N+2*N+1)  = step_col_block*L + FPR_OFFSET
- step_done  in  1  pass complete (one-cycle)
- step_fail  in  1  pivot failure; valid in the step_done cycle

Behaviour:
- Derived constants: NB = K/N column blocks; NP = ceil(L/N) phases.
- Reset values: every output is 0, state is IDLE, phase = 0, cblk = 0. Reset mid-sweep aborts immediately with no done and no fail.
- States: IDLE, ISSUE, WAIT, GAP, FINISH, FAIL.
- IDLE/FINISH/FAIL, go=1 → ISSUE. On this transition: phase=0, cblk=0, functionA=1, fail=0, timeout=0.
- ISSUE: step_start=1 for exactly one cycle → WAIT. The watchdog counter clears.
- WAIT: watchdog increments every cycle.
  - step_done with (functionA && step_fail) → FAIL; fail=1; fail_phase=phase.
  - step_done otherwise → GAP, and the next pass is computed:
    - after functionA: cblk = phase+1, functionA = 0;
    - after functionB: cblk = cblk+1;
    - if the new cblk == NB: phase = phase+1, cblk = phase (the new phase), functionA = 1;
    - if the new phase == NP: the sweep is finished.
  - step_fail is ignored when functionA=0.
  - Watchdog reaches TIMEOUT-1 without step_done → FAIL; fail=1; timeout=1.
- GAP: wait exactly GAP cycles, then go to ISSUE, or to FINISH if the sweep is finished. done pulses on the cycle FINISH is entered.
- A step_done arriving outside WAIT is ignored.
- step_col_block, step_functionA, step_last_phase and step_first_pass_rows are registered. They change only on the ISSUE-entry cycle and hold constant through WAIT.
- step_last_phase = (phase == NP-1).
- Arithmetic: cblk*L + FPR_OFFSET is computed at port width, no overflow for legal parameters. Phase and cblk compare against NP/NB with no wrap.
- go while busy is ignored. go in the same cycle as rst: rst wins.
- Minimum start-to-start spacing: 1 (ISSUE) + WAIT + GAP cycles.

Test Plan:
- Defaults (NB=4, NP=2), step model returns done 20 cycles after start, fail=0 → exactly 7 starts, in this order:
  - (A,0) (B,1) (B,2) (B,3) (A,1) (B,2) (B,3);
  - last_phase=1 on the final 3 only;
  - first_pass_rows = 8 on the first start, 16 on the fifth;
  - done pulses once; busy is high throughout; host_gnt is low throughout.
- step_fail=1 with step_done on the 5th pass (A,1) → fail=1, fail_phase=1, no further starts, no done, host_gnt=1.
- step_fail=1 during a functionB pass → ignored; the sweep completes with done.
- step model never returns done → fail=1 and timeout=1 exactly TIMEOUT cycles after step_start; a subsequent go clears both and restarts at (A,0).
- rst asserted during the 3rd WAIT → next cycle all outputs 0, state IDLE; a fresh go produces the full 7-pass sequence.
- go pulsed repeatedly during a sweep → no extra starts. Spacing between step_done and the next step_start is exactly GAP+1 cycles.

Source files
------------

// File: rtl/step_scheduler.sv
// Sequencer for the systolic-line step datapath: runs one GF(M) Gaussian-elimination
// sweep as a series of functionA/functionB passes, with gap insertion and a watchdog.
module step_scheduler #(
    parameter int N          = 4,
    parameter int M          = 3,
    parameter int L          = 8,
    parameter int K          = 16,
    parameter int GAP        = 2,
    parameter int FPR_OFFSET = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    output logic                              busy,
    output logic                              done,
    output logic                              fail,
    output logic                              timeout,
    output logic [$clog2(L/N+2)-1:0]          fail_phase,
    output logic                              host_gnt,
    output logic                              step_start,
    output logic                              step_functionA,
    output logic                              step_last_phase,
    output logic [$clog2(K/N+1)-1:0]          step_col_block,
    output logic [$clog2(L*K/N+2*N+1)-1:0]    step_first_pass_rows,
    input  logic                              step_done,
    input  logic                              step_fail
);

    localparam int NB = K / N;
    localparam int NP = (L + N - 1) / N;
    localparam int PW = $clog2(L/N+2);
    localparam int CW = $clog2(K/N+1);
    localparam int FW = $clog2(L*K/N+2*N+1);
    localparam int WW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP+1);

    localparam logic [PW-1:0] NP_V    = PW'(NP);
    localparam logic [PW-1:0] LASTP_V = PW'(NP-1);
    localparam logic [CW-1:0] NB_V    = CW'(NB);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT-1);
    localparam logic [GW-1:0] GAP_END = GW'(GAP-1);

    if (((K % N) != 0) || (L > K) || (GAP < 1) || (TIMEOUT < 2) || (M < 2)) begin : g_bad_params
        $error("step_scheduler: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [CW-1:0]   cblk_q, cblk_d;
    logic            fa_q, fa_d;
    logic            finished_q, finished_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic            timeout_q, timeout_d;
    logic [PW-1:0]   fail_phase_q, fail_phase_d;
    logic            host_gnt_q, host_gnt_d;
    logic            start_q, start_d;
    logic            sfa_q, sfa_d;
    logic            slast_q, slast_d;
    logic [CW-1:0]   scb_q, scb_d;
    logic [FW-1:0]   sfpr_q, sfpr_d;

    logic            enter_issue;
    logic [CW-1:0]   nxt_cblk;
    logic [PW-1:0]   nxt_phase;
    logic            nxt_fa;

    // Next-state, pass bookkeeping and registered-output computation.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cblk_d       = cblk_q;
        fa_d         = fa_q;
        finished_d   = finished_q;
        wdog_d       = wdog_q;
        gcnt_d       = gcnt_q;
        done_d       = 1'b0;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        fail_phase_d = fail_phase_q;
        enter_issue  = 1'b0;
        nxt_cblk     = fa_q ? (CW'(phase_q) + CW'(1)) : (cblk_q + CW'(1));
        nxt_phase    = phase_q;
        nxt_fa       = 1'b0;

        if (nxt_cblk == NB_V) begin
            nxt_phase = phase_q + PW'(1);
            nxt_cblk  = CW'(nxt_phase);
            nxt_fa    = 1'b1;
        end else begin
            nxt_phase = phase_q;
        end

        case (state_q)
            S_IDLE, S_FINISH, S_FAIL: begin
                if (go) begin
                    state_d      = S_ISSUE;
                    phase_d      = '0;
                    cblk_d       = '0;
                    fa_d         = 1'b1;
                    finished_d   = 1'b0;
                    fail_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_phase_d = '0;
                    enter_issue  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wdog_d  = wdog_q + WW'(1);
            end
            S_WAIT: begin
                wdog_d = wdog_q + WW'(1);
                if (step_done) begin
                    if (fa_q && step_fail) begin
                        state_d      = S_FAIL;
                        fail_d       = 1'b1;
                        fail_phase_d = phase_q;
                    end else begin
                        state_d    = S_GAP;
                        gcnt_d     = '0;
                        cblk_d     = nxt_cblk;
                        phase_d    = nxt_phase;
                        fa_d       = nxt_fa;
                        finished_d = (nxt_phase == NP_V);
                    end
                end else if (wdog_q == WD_MAX) begin
                    state_d      = S_FAIL;
                    fail_d       = 1'b1;
                    timeout_d    = 1'b1;
                    fail_phase_d = phase_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_END) begin
                    if (finished_q) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        enter_issue = 1'b1;
                    end
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pass descriptor is latched only as ISSUE is entered and held through WAIT.
        if (enter_issue) begin
            start_d = 1'b1;
            wdog_d  = '0;
            sfa_d   = fa_d;
            scb_d   = cblk_d;
            slast_d = (phase_d == LASTP_V);
            sfpr_d  = (FW'(cblk_d) * FW'(L)) + FW'(FPR_OFFSET);
        end else begin
            start_d = 1'b0;
            sfa_d   = sfa_q;
            scb_d   = scb_q;
            slast_d = slast_q;
            sfpr_d  = sfpr_q;
        end

        busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_GAP);
        host_gnt_d = ~busy_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            cblk_q       <= '0;
            fa_q         <= 1'b0;
            finished_q   <= 1'b0;
            wdog_q       <= '0;
            gcnt_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_phase_q <= '0;
            host_gnt_q   <= 1'b0;
            start_q      <= 1'b0;
            sfa_q        <= 1'b0;
            slast_q      <= 1'b0;
            scb_q        <= '0;
            sfpr_q       <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cblk_q       <= cblk_d;
            fa_q         <= fa_d;
            finished_q   <= finished_d;
            wdog_q       <= wdog_d;
            gcnt_q       <= gcnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            fail_phase_q <= fail_phase_d;
            host_gnt_q   <= host_gnt_d;
            start_q      <= start_d;
            sfa_q        <= sfa_d;
            slast_q      <= slast_d;
            scb_q        <= scb_d;
            sfpr_q       <= sfpr_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign fail                 = fail_q;
    assign timeout              = timeout_q;
    assign fail_phase           = fail_phase_q;
    assign host_gnt             = host_gnt_q;
    assign step_start           = start_q;
    assign step_functionA       = sfa_q;
    assign step_last_phase      = slast_q;
    assign step_col_block       = scb_q;
    assign step_first_pass_rows = sfpr_q;

endmodule
